// File: rtl/maxpool_stream_if.sv
// Valid/ready stream bundle carrying one signed T-bit sample per transfer.
interface maxpool_stream_if #(
    parameter int unsigned T = 16
) ();
    logic [T-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 1D max-pool: reduces each non-overlapping window of P samples of an
// L-sample vector to its signed maximum; trailing samples beyond (L/P)*P are dropped.
module maxpool_stream #(
    parameter int unsigned L = 13,
    parameter int unsigned P = 2,
    parameter int unsigned T = 16
) (
    input  logic             clk,
    input  logic             reset,
    maxpool_stream_if.slave  x,
    maxpool_stream_if.master y
);
    localparam int unsigned FULL = (L / P) * P;
    localparam int unsigned EW   = (L > 1) ? $clog2(L) : 1;
    localparam int unsigned WW   = $clog2(P);

    logic [EW-1:0]       elem_cnt;
    logic [WW-1:0]       win_cnt;
    logic signed [T-1:0] max_reg;
    logic signed [T-1:0] y_data_q;
    logic                y_valid_q;

    logic signed [T-1:0] x_s;
    logic signed [T-1:0] pool_max;
    logic                x_acc;
    logic                y_acc;
    logic                win_first;
    logic                win_last;
    logic                vec_last;
    logic                in_full;
    logic                win_done;

    // One-entry output register: refillable in the same cycle it drains.
    assign x.ready = !y_valid_q || y.ready;
    assign y.valid = y_valid_q;
    assign y.data  = y_data_q;

    always_comb begin
        x_s       = $signed(x.data);
        pool_max  = (x_s > max_reg) ? x_s : max_reg;
        x_acc     = x.valid && x.ready;
        y_acc     = y_valid_q && y.ready;
        win_first = (win_cnt == '0);
        win_last  = (win_cnt == WW'(P - 1));
        vec_last  = (elem_cnt == EW'(L - 1));
        in_full   = (32'(elem_cnt) < FULL);
        win_done  = x_acc && win_last && in_full;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            elem_cnt  <= '0;
            win_cnt   <= '0;
            max_reg   <= '0;
            y_data_q  <= '0;
            y_valid_q <= 1'b0;
        end else begin
            if (x_acc) begin
                // End of vector forces a fresh window regardless of win_cnt.
                if (vec_last) begin
                    elem_cnt <= '0;
                    win_cnt  <= '0;
                end else begin
                    elem_cnt <= elem_cnt + 1'b1;
                    win_cnt  <= win_last ? '0 : win_cnt + 1'b1;
                end
                if (win_first) begin
                    max_reg <= x_s;
                end else if (!win_last) begin
                    max_reg <= pool_max;
                end
            end
            if (win_done) begin
                y_valid_q <= 1'b1;
                y_data_q  <= pool_max;
            end else if (y_acc) begin
                y_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/maxpool_stream.md
Name: maxpool_stream

Overview:
- Streaming 1D max-pool stage that sits on the output side of the 1D convolution engine.
- Its x-side valid/ready port is the consumer end of the convolution engine's y-side port.
- Receives vectors of L post-ReLU convolution outputs and reduces each non-overlapping window of P samples to its signed maximum.
- Presents L/P (floor) pooled results on a valid/ready output port toward the next layer or the result collector.

Parameters:
L, 13, samples per input vector (convolution output length, N-M+1); L >= P
P, 2, pool window size and stride; P >= 2
T, 16, data width in bits, signed two's complement

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
x_data  input  T  signed input sample from the convolution engine
x_valid  input  1  x_data valid
x_ready  output  1  block accepts x_data this cycle
y_data  output  T  signed pooled result
y_valid  output  1  y_data valid
y_ready  input  1  downstream accepts y_data this cycle

Behaviour:
- Reset asserted (reset=0, async): y_valid=0, y_data=0, win_cnt=0, elem_cnt=0, max_reg=0.
- Since x_ready is combinational, x_ready=1 while in reset and immediately after reset.
- Accept: x_acc = x_valid && x_ready. Output transfer: y_acc = y_valid && y_ready.
- x_ready = !y_valid || y_ready, combinational. This is a one-entry output register that can be refilled in the same cycle it drains.
- x_ready does not depend on x_valid.
- Counters:
  - win_cnt runs 0..P-1.
  - elem_cnt runs 0..L-1 and advances only on x_acc.
  - When elem_cnt == L-1 on x_acc, both counters wrap to 0, so the next vector starts a fresh window.
  - Otherwise win_cnt wraps to 0 after P-1.
- Full-window region: elem_cnt < FULL, where FULL = (L/P)*P (integer divide).
- On x_acc with win_cnt == 0: max_reg <= x_data.
- On x_acc with 0 < win_cnt < P-1: max_reg <= signed max(max_reg, x_data).
- On x_acc with win_cnt == P-1 and elem_cnt < FULL:
  - y_data <= signed max(max_reg, x_data), y_valid <= 1.
  - Latency is exactly 1 cycle: y_valid rises on the edge that accepts the window's last sample.
- Tail samples (elem_cnt >= FULL) are accepted, take part in counting, and are discarded. They never produce output.
- Clearing y_valid: y_acc with no simultaneous window completion clears y_valid to 0.
- y_acc together with a window completion keeps y_valid=1 and loads the new y_data.
- y_data and y_valid are stable while y_valid=1 && y_ready=0.
- y_data keeps its last value after a transfer. It is don't-care when y_valid=0, but the bench checks it only when valid.
- Comparison is signed over the full T bits. On ties either operand is the same value. There is no width growth or saturation.
- Throughput: one sample per cycle sustained when y_ready=1.
- Pooled outputs per vector: L/P.
- Reset mid-operation: the partial window and any pending output are dropped, and counters restart at 0. The next accepted sample is element 0 of a new vector.
- Samples offered while x_ready=0 are not consumed. The upstream engine holds them per the valid/ready rule.
- Implementation: a small controller (counter compare logic plus output register), 120-250 lines.

Test Plan:
- Defaults, x = 1..13 streamed back-to-back, y_ready=1 -> y = 2,4,6,8,10,12, each y_valid one cycle after the accept of the even sample; x_ready stays 1 throughout; 13 is accepted and discarded.
- Backpressure: y_ready=0 for 5 cycles when the first result (2) appears -> y_valid=1 and y_data=2 held; x_ready=0 during the stall; no sample is lost; final sequence is unchanged (2,4,6,8,10,12).
- Signed: x = -5,-3, 7,-8, 0,0, -1,-32768, 32767,1, -2,-2, 9 -> y = -3,7,0,-1,32767,-2.
- Two vectors back-to-back (26 samples 1..26) -> second vector yields 15,17,19,21,23,25; window alignment restarts at sample 14; 26 is discarded.
- Reset pulse (reset=0 for 1 cycle) after 3 samples of the first vector -> y_valid drops immediately; streaming 1..13 afterwards yields exactly 2,4,...,12.
- P=3, L=10, x = 3,1,2, 4,9,0, 5,5,5, 7 -> y = 3,9,5; 7 is discarded.
